// File: rtl/deadlock_idx0_monitor.sv
// Deadlock detector for dataflow region 0: sticky `block` after STALL_THRESHOLD
// blocked cycles without input change. Define DEADLOCK_MON_DIAG_EN for snapshot outputs.
module deadlock_idx0_monitor #(
  parameter int NUM_AXIS        = 2,
  parameter int NUM_INST        = 3,
  parameter int NUM_IBLK        = 1,
  parameter int STALL_THRESHOLD = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_IBLK-1:0] inst_block_sigs,
`ifdef DEADLOCK_MON_DIAG_EN
  output logic [NUM_AXIS-1:0] diag_axis_snap,
  output logic [NUM_INST-1:0] diag_inst_snap,
  output logic [NUM_IBLK-1:0] diag_iblk_snap,
  output logic [31:0]         diag_cycle,
`endif
  output logic                block
);

  // state   | meaning
  // IDLE    | no block flag set, counter cleared
  // WATCH   | some block flag set, counting unchanged cycles
  // BLOCKED | deadlock declared, held until reset
  typedef enum logic [1:0] {ST_IDLE, ST_WATCH, ST_BLOCKED} state_t;

  localparam int          SIG_W    = NUM_AXIS + NUM_INST + NUM_IBLK;
  localparam logic [15:0] CNT_LAST = 16'(STALL_THRESHOLD - 1);

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic               block_q, block_d;
  logic               any_blk;
  logic               stalled;

  assign sig_d   = {inst_block_sigs, inst_idle_sigs, axis_block_sigs};
  assign any_blk = (|axis_block_sigs) | (|inst_block_sigs);
  // X/Z inputs make the compare unknown; the if below then treats it as progress
  assign stalled = any_blk & (sig_d == sig_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sig_q   <= '0;
      block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      block_q <= block_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (any_blk) state_d = ST_WATCH;
      end
      ST_WATCH: begin
        if (!any_blk) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (stalled) begin
          if (cnt_q == CNT_LAST) state_d = ST_BLOCKED;
          else                   cnt_d   = cnt_q + 16'd1;
        end else begin
          cnt_d = '0;
        end
      end
      ST_BLOCKED: begin
        state_d = ST_BLOCKED;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    block_d = (state_d == ST_BLOCKED);
  end

  assign block = block_q;

`ifdef DEADLOCK_MON_DIAG_EN
  logic [31:0]         cyc_q, cyc_d;
  logic [NUM_AXIS-1:0] axis_snap_q, axis_snap_d;
  logic [NUM_INST-1:0] inst_snap_q, inst_snap_d;
  logic [NUM_IBLK-1:0] iblk_snap_q, iblk_snap_d;
  logic [31:0]         dcyc_q, dcyc_d;
  logic                block_rise;

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_q       <= '0;
      axis_snap_q <= '0;
      inst_snap_q <= '0;
      iblk_snap_q <= '0;
      dcyc_q      <= '0;
    end else begin
      cyc_q       <= cyc_d;
      axis_snap_q <= axis_snap_d;
      inst_snap_q <= inst_snap_d;
      iblk_snap_q <= iblk_snap_d;
      dcyc_q      <= dcyc_d;
    end
  end

  // diag_cycle records the counter value including the rising edge itself
  always_comb begin
    cyc_d       = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
    block_rise  = block_d & ~block_q;
    axis_snap_d = block_rise ? axis_block_sigs : axis_snap_q;
    inst_snap_d = block_rise ? inst_idle_sigs  : inst_snap_q;
    iblk_snap_d = block_rise ? inst_block_sigs : iblk_snap_q;
    dcyc_d      = block_rise ? cyc_d           : dcyc_q;
  end

  assign diag_axis_snap = axis_snap_q;
  assign diag_inst_snap = inst_snap_q;
  assign diag_iblk_snap = iblk_snap_q;
  assign diag_cycle     = dcyc_q;
`endif

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// Scoreboard bench for deadlock_idx0_monitor: directed plan scenarios plus random
// held-input segments, checked against a run-length reference model.
module tb_deadlock_idx0_monitor;
  localparam int THR = 8;

  logic       clock;
  logic       reset;
  logic [1:0] axis_block_sigs;
  logic [2:0] inst_idle_sigs;
  logic [0:0] inst_block_sigs;
  logic       block;
`ifdef DEADLOCK_MON_DIAG_EN
  logic [1:0]  diag_axis_snap;
  logic [2:0]  diag_inst_snap;
  logic [0:0]  diag_iblk_snap;
  logic [31:0] diag_cycle;
`endif

  deadlock_idx0_monitor #(
    .NUM_AXIS(2), .NUM_INST(3), .NUM_IBLK(1), .STALL_THRESHOLD(THR)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
`ifdef DEADLOCK_MON_DIAG_EN
    .diag_axis_snap  (diag_axis_snap),
    .diag_inst_snap  (diag_inst_snap),
    .diag_iblk_snap  (diag_iblk_snap),
    .diag_cycle      (diag_cycle),
`endif
    .block           (block)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        blk;
    logic [1:0]  ax;
    logic [2:0]  in;
    logic        ib;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: length of the current run of identical, blocked input samples
  int          run_len = 0;
  logic [5:0]  prev_sig = '0;
  logic        m_blk = 1'b0;
  logic [1:0]  m_ax = '0;
  logic [2:0]  m_in = '0;
  logic        m_ib = 1'b0;
  longint      m_cyc = 0;
  logic [31:0] m_dcyc = '0;

  task automatic apply(input logic r, input logic [1:0] a, input logic [2:0] i,
                       input logic b);
    exp_t       e;
    logic [5:0] s;
    reset = r; axis_block_sigs = a; inst_idle_sigs = i; inst_block_sigs = b;
    s = {b, i, a};
    if (r) begin
      run_len = 0; m_blk = 1'b0; m_cyc = 0;
      m_ax = '0; m_in = '0; m_ib = 1'b0; m_dcyc = '0;
    end else begin
      if (m_cyc < 64'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if ((a != 2'b00) || b) run_len = (run_len > 0 && s == prev_sig) ? run_len + 1 : 1;
      else                   run_len = 0;
      if (!m_blk && run_len >= THR + 1) begin
        m_blk = 1'b1; m_ax = a; m_in = i; m_ib = b; m_dcyc = m_cyc[31:0];
      end
    end
    prev_sig = s;
    e.blk = m_blk; e.ax = m_ax; e.in = m_in; e.ib = m_ib; e.cyc = m_dcyc;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic hold(input logic r, input logic [1:0] a, input logic [2:0] i,
                      input logic b, input int n);
    for (int k = 0; k < n; k++) apply(r, a, i, b);
  endtask

  // Monitor: block is a registered level, so one scoreboard entry per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (block !== e.blk) begin
          n_err++;
          $display("FAIL block t=%0t got=%b want=%b", $time, block, e.blk);
        end
`ifdef DEADLOCK_MON_DIAG_EN
        n_cmp++;
        if (diag_axis_snap !== e.ax || diag_inst_snap !== e.in ||
            diag_iblk_snap !== e.ib || diag_cycle !== e.cyc) begin
          n_err++;
          $display("FAIL diag t=%0t got=%b/%b/%b/%0d want=%b/%b/%b/%0d", $time,
                   diag_axis_snap, diag_inst_snap, diag_iblk_snap, diag_cycle,
                   e.ax, e.in, e.ib, e.cyc);
        end
`endif
      end
    end
  end

  initial begin
    int wait_cyc;
    // Plan 1: constant block from cycle t, stays sticky for 50 more cycles
    hold(1, 2'b00, 3'b000, 0, 2);
    hold(0, 2'b00, 3'b000, 0, 3);
    hold(0, 2'b01, 3'b010, 0, 60);
    // Plan 2: a single idle toggle restarts the count
    hold(1, 2'b00, 3'b000, 0, 2);
    hold(0, 2'b10, 3'b000, 0, 5);
    hold(0, 2'b10, 3'b010, 0, 1);
    hold(0, 2'b10, 3'b000, 0, 14);
    // Plan 3: a one-cycle release returns to IDLE
    hold(1, 2'b00, 3'b000, 0, 2);
    hold(0, 2'b11, 3'b000, 0, 6);
    hold(0, 2'b00, 3'b000, 0, 1);
    hold(0, 2'b11, 3'b000, 0, 14);
    // Plan 4: idle flags alone never declare a deadlock
    hold(1, 2'b00, 3'b000, 0, 2);
    hold(0, 2'b00, 3'b110, 0, 100);
    // Plan 5: reset out of BLOCKED, then re-block with inputs unchanged
    hold(0, 2'b01, 3'b001, 0, 12);
    hold(1, 2'b01, 3'b001, 0, 1);
    hold(0, 2'b01, 3'b001, 0, 14);
    // Plan 6: instance block flag only, applied 10 cycles after reset release
    hold(1, 2'b00, 3'b000, 0, 2);
    hold(0, 2'b00, 3'b000, 0, 10);
    hold(0, 2'b00, 3'b100, 1, 14);
    // Random held segments, long enough to reach the threshold often
    for (int seg = 0; seg < 300; seg++) begin
      logic r;
      r = ($urandom_range(0, 39) == 0);
      hold(r, 2'($urandom), 3'($urandom), 1'($urandom_range(0, 3) == 0),
           r ? 1 : int'($urandom_range(1, 12)));
    end
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clock);
      wait_cyc++;
    end
    #5;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
